// File: rtl/normalizador_redondeo.sv
// normalizador_redondeo: 2-stage valid/ready normalize + round + range-check stage of the 13-bit FP multiplier
// Format {sign, exp[3:0], mant[7:0]}, bias BIAS, implicit leading 1, exponent field 0 means zero.
// Ports:
//   i_clock, i_reset (async, active-high)
//   i_valido / o_listo_entrada : upstream handshake
//   i_signo, i_exponente_suma[4:0], i_producto[17:0], i_cero : operand from the product datapath
//   o_valido / i_listo : downstream handshake
//   o_flotante[12:0], o_overflow, o_underflow : result and saturation / flush flags
// Macro NORMALIZADOR_RNE_EN: defined -> round to nearest, ties to even; undefined -> truncation.
module normalizador_redondeo #(
  parameter int BIAS = 7
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valido,
  output logic        o_listo_entrada,
  input  logic        i_signo,
  input  logic [4:0]  i_exponente_suma,
  input  logic [17:0] i_producto,
  input  logic        i_cero,
  output logic        o_valido,
  input  logic        i_listo,
  output logic [12:0] o_flotante,
  output logic        o_overflow,
  output logic        o_underflow
);
  logic v1, v2, s1, z1, en1, en2, n, carry, ovf, unf;
  logic signed [6:0] e1, e_n, e_r;
  logic [7:0] f1, f_n, f_r;
  logic [12:0] res;
  assign en2 = !v2 | i_listo;
  assign en1 = !v1 | en2;
  assign o_listo_entrada = en1;
  assign o_valido = v2;
  assign n = i_producto[17];
  assign f_n = n ? i_producto[16:9] : i_producto[15:8];
  // 7-bit two's complement wraps correctly for sums below BIAS
  assign e_n = 7'(i_exponente_suma) - 7'(BIAS) + 7'(n);
`ifdef NORMALIZADOR_RNE_EN
  logic g1, t1, g_n, t_n, inc;
  assign g_n = n ? i_producto[8] : i_producto[7];
  assign t_n = n ? |i_producto[7:0] : |i_producto[6:0];
  assign inc = g1 & (t1 | f1[0]);
  // a carry out of the fraction means 1.11111111 rounded up to 10.0: fraction wraps to 0, exponent bumps
  assign {carry, f_r} = {1'b0, f1} + 9'(inc);
`else
  logic unused_bits;
  assign unused_bits = ^i_producto[7:0];
  assign {carry, f_r} = {1'b0, f1};
`endif
  assign e_r = e1 + 7'(carry);
  assign ovf = !z1 & (e_r > 7'sd15);
  assign unf = !z1 & !ovf & (e_r < 7'sd1);
  assign res = (z1 | unf) ? {s1, 12'h000} : ovf ? {s1, 12'hFFF} : {s1, e_r[3:0], f_r};
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      v1 <= 1'b0;
      s1 <= 1'b0;
      z1 <= 1'b0;
      e1 <= '0;
      f1 <= '0;
`ifdef NORMALIZADOR_RNE_EN
      g1 <= 1'b0;
      t1 <= 1'b0;
`endif
    end else if (en1) begin
      v1 <= i_valido;
      if (i_valido) begin
        s1 <= i_signo;
        z1 <= i_cero;
        e1 <= e_n;
        f1 <= f_n;
`ifdef NORMALIZADOR_RNE_EN
        g1 <= g_n;
        t1 <= t_n;
`endif
      end
    end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      v2 <= 1'b0;
      o_flotante <= '0;
      o_overflow <= 1'b0;
      o_underflow <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        o_flotante <= res;
        o_overflow <= ovf;
        o_underflow <= unf;
      end
    end
endmodule
